alu_uart_ctrl: RTL
==================

# alu_uart_ctrl

Sequencer that feeds the ALU from a received byte stream instead of switches and buttons. It collects three bytes in order (operand A, operand B, opcode), applies them to the ALU atomically, and captures the ALU result. It then offers the result to a transmitter with a valid/ready handshake. It sits between the UART RX/TX blocks and the combinational ALU in the top level.

## Interface
- `NB_DATA`, 8, width of operands, result and RX/TX bytes
- `NB_OP`, 6, opcode width; taken from the low bits of the third byte
- `TIMEOUT_CYCLES`, 1000000, inter-byte timeout in clock cycles; used only with the timeout macro

- `clk` in 1: single clock; all logic on posedge
- `i_rst` in 1: reset, synchronous, active-high
- `i_rx_data` in NB_DATA: received byte
- `i_rx_valid` in 1: one-cycle pulse; `i_rx_data` is valid this cycle
- `o_data_a` out NB_DATA: operand A to the ALU
- `o_data_b` out NB_DATA: operand B to the ALU
- `o_op` out NB_OP: opcode to the ALU
- `i_alu_result` in NB_DATA: combinational ALU result
- `o_tx_data` out NB_DATA: captured result for the transmitter
- `o_tx_valid` out 1: result available; held until accepted
- `i_tx_ready` in 1: transmitter accepts when high with `o_tx_valid`
- `o_overrun` out 1: one-cycle pulse, byte dropped while busy
- `o_timeout` out 1: one-cycle pulse, partial frame abandoned

## Operation
- States: WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND. Reset state is WAIT_A.
- Reset values: all outputs are 0, the shadow registers are 0, and the timeout counter is 0.
- WAIT_A: `i_rx_valid` stores the byte in shadow A and moves to WAIT_B.
- WAIT_B: `i_rx_valid` stores the byte in shadow B and moves to WAIT_OP.
- WAIT_OP: `i_rx_valid` commits all operands on the same edge and moves to EXEC.
  - `o_data_a` gets shadow A.
  - `o_data_b` gets shadow B.
  - `o_op` gets `i_rx_data[NB_OP-1:0]`; upper bits are ignored.
- The ALU operands therefore never show a partially loaded frame.
- EXEC (exactly 1 cycle): on its closing edge, `o_tx_data` gets `i_alu_result`, `o_tx_valid` goes to 1, and the state moves to SEND.
- SEND: `o_tx_valid` stays 1 and `o_tx_data` stays stable until a cycle with `i_tx_ready`=1.
  - On that edge `o_tx_valid` goes to 0 and the state moves to WAIT_A.
  - There is no timeout in SEND.
- `o_data_a`, `o_data_b`, `o_op` and `o_tx_data` keep their last values after the transaction, so the ALU output stays observable.
- `i_rx_valid` in EXEC or SEND: the byte is discarded, and `o_overrun`=1 on the following cycle only. State and data are unaffected.
- Reset mid-frame or mid-SEND: returns to WAIT_A with reset values; a pending result is lost.
- No arithmetic is done in this block; the result width equals NB_DATA, with the sign interpretation left to the ALU.

## Timing
- Latency: opcode byte accepted at edge N; operands visible after N; result captured and `o_tx_valid`=1 after edge N+1.
- Minimum frame-to-frame time is 3 RX pulses + 2 cycles, when `i_tx_ready` is held high.
- RX bytes may arrive on consecutive cycles; one byte is accepted per cycle.
- `o_overrun` and `o_timeout` are registered, one cycle wide, and never high together.

## Configuration
- Macro: `ALU_UART_CTRL_TIMEOUT_EN`.
- Defined:
  - A counter of `$clog2(TIMEOUT_CYCLES)` bits runs in WAIT_B and WAIT_OP.
  - It clears on every accepted byte and on state entry.
  - When it reaches TIMEOUT_CYCLES-1 without a byte, the block goes to WAIT_A and `o_timeout` pulses on the next cycle.
  - Shadows are discarded; ALU outputs are unchanged.
  - A byte arriving in the same cycle as expiry is accepted, and the timeout does not fire.
- Undefined: no counter; `o_timeout` is tied to 0; a partial frame waits indefinitely.

## Test plan
- Reset then RX 8'h05, 8'h03, 8'h20 (ADD), with `i_tx_ready`=1 → `o_op`=6'h20; `o_tx_data`=8'h08 with `o_tx_valid` 1 cycle after opcode commit, for one cycle.
- RX 8'hF0, 8'h0F, 8'hE4 → `o_op`=6'h24 (upper bits dropped); `o_data_a`/`o_data_b` stay at the old values until the third byte.
- `i_tx_ready`=0 for 10 cycles in SEND → `o_tx_valid` and `o_tx_data` stable; RX pulse during that time → `o_overrun` one cycle; next frame unaffected.
- `i_rst` asserted in WAIT_OP and in SEND → all outputs 0 next cycle; the following full frame behaves as in the first scenario.
- With macro, TIMEOUT_CYCLES=16: RX 8'h11 then silence → `o_timeout` pulse, state WAIT_A.
  - Next frame 8'h02, 8'h02, 8'h20 → result 8'h04.
  - Without macro, the same stimulus waits, and a later 8'h22, 8'h20 completes the frame with A=8'h11.

Source files
------------

// File: rtl/alu_uart_ctrl.sv
// Byte-stream sequencer for the ALU: collects A, B, opcode; commits atomically; offers result via valid/ready.
// Optional inter-byte timeout enabled by defining ALU_UART_CTRL_TIMEOUT_EN.
module alu_uart_ctrl #(
  parameter int NB_DATA        = 8,
  parameter int NB_OP          = 6,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_valid,
  output logic [NB_DATA-1:0] o_data_a,
  output logic [NB_DATA-1:0] o_data_b,
  output logic [NB_OP-1:0]   o_op,
  input  logic [NB_DATA-1:0] i_alu_result,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_valid,
  input  logic               i_tx_ready,
  output logic               o_overrun,
  output logic               o_timeout,
  output logic [2:0]         o_state
);

  // Handshake: a result transfers on a cycle where o_tx_valid and i_tx_ready are both 1;
  // o_tx_valid and o_tx_data hold steady until then, and valid never drops without that transfer.

  typedef enum logic [2:0] {
    WAIT_A  = 3'd0,
    WAIT_B  = 3'd1,
    WAIT_OP = 3'd2,
    EXEC    = 3'd3,
    SEND    = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [NB_DATA-1:0] shadow_a_q, shadow_a_d;
  logic [NB_DATA-1:0] shadow_b_q, shadow_b_d;
  logic [NB_DATA-1:0] data_a_q, data_a_d;
  logic [NB_DATA-1:0] data_b_q, data_b_d;
  logic [NB_OP-1:0]   op_q, op_d;
  logic [NB_DATA-1:0] tx_data_q, tx_data_d;
  logic               tx_valid_q, tx_valid_d;
  logic               overrun_q, overrun_d;
  logic               tmo_hit;

`ifdef ALU_UART_CTRL_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             timeout_q, timeout_d;

  assign tmo_hit = (tmo_cnt_q == TMO_LAST);

  // Counts idle cycles inside a partial frame; any accepted byte or other state clears it.
  always_comb begin
    tmo_cnt_d = '0;
    if ((state_q == WAIT_B || state_q == WAIT_OP) && !i_rx_valid && !tmo_hit)
      tmo_cnt_d = tmo_cnt_q + 1'b1;
  end

  always_comb begin
    timeout_d = 1'b0;
    if ((state_q == WAIT_B || state_q == WAIT_OP) && !i_rx_valid && tmo_hit)
      timeout_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      tmo_cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_timeout = timeout_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = |TIMEOUT_CYCLES;
  assign tmo_hit   = 1'b0;
  assign o_timeout = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    shadow_a_d = shadow_a_q;
    shadow_b_d = shadow_b_q;
    data_a_d   = data_a_q;
    data_b_d   = data_b_q;
    op_d       = op_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    overrun_d  = 1'b0;
    case (state_q)
      WAIT_A: begin
        if (i_rx_valid) begin
          shadow_a_d = i_rx_data;
          state_d    = WAIT_B;
        end
      end
      WAIT_B: begin
        if (i_rx_valid) begin
          shadow_b_d = i_rx_data;
          state_d    = WAIT_OP;
        end else if (tmo_hit) begin
          shadow_a_d = '0;
          shadow_b_d = '0;
          state_d    = WAIT_A;
        end
      end
      WAIT_OP: begin
        // All three ALU inputs update on one edge so the ALU never sees a mixed frame.
        if (i_rx_valid) begin
          data_a_d = shadow_a_q;
          data_b_d = shadow_b_q;
          op_d     = i_rx_data[NB_OP-1:0];
          state_d  = EXEC;
        end else if (tmo_hit) begin
          shadow_a_d = '0;
          shadow_b_d = '0;
          state_d    = WAIT_A;
        end
      end
      EXEC: begin
        overrun_d  = i_rx_valid;
        tx_data_d  = i_alu_result;
        tx_valid_d = 1'b1;
        state_d    = SEND;
      end
      SEND: begin
        overrun_d = i_rx_valid;
        if (i_tx_ready) begin
          tx_valid_d = 1'b0;
          state_d    = WAIT_A;
        end
      end
      default: state_d = WAIT_A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q    <= WAIT_A;
      shadow_a_q <= '0;
      shadow_b_q <= '0;
      data_a_q   <= '0;
      data_b_q   <= '0;
      op_q       <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      shadow_a_q <= shadow_a_d;
      shadow_b_q <= shadow_b_d;
      data_a_q   <= data_a_d;
      data_b_q   <= data_b_d;
      op_q       <= op_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      overrun_q  <= overrun_d;
    end
  end

  assign o_data_a   = data_a_q;
  assign o_data_b   = data_b_q;
  assign o_op       = op_q;
  assign o_tx_data  = tx_data_q;
  assign o_tx_valid = tx_valid_q;
  assign o_overrun  = overrun_q;
  assign o_state    = state_q;

endmodule
